io_mux_controller: RTL
======================

Name: io_mux_controller

Overview:
- Shares the 38 user I/O pads between up to NUM_DESIGNS user cores (the AS2650 wrapper plus sibling designs) behind one user_project_wrapper.
- Firmware selects the active design through a small Wishbone slave.
- Every design switch runs a safe sequence: pads tristated, all cores held in reset, then the new core is released with its out/oeb routed to the pads.
- Non-selected cores are always held in reset. io_in is broadcast to all cores in the wrapper and does not pass through this block.

Parameters:
- NUM_IO, 38, pad count.
- NUM_DESIGNS, 4, number of selectable cores (2..8).
- DEFAULT_SEL, 0, design selected after wb_rst_i.
- GUARD_CYC, 8, cycles pads stay tristated before reset hold begins (>=1).
- RST_HOLD, 16, cycles the new design is held in reset with pads still tristated (>=1).
- BASE_ADDR, 32'h3000_0000, Wishbone window base; 256-byte window.

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  asynchronous, active-high reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write enable
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_sel_i  in  4  byte lanes; CTRL write requires sel[0]
- wbs_ack_o  out  1  single-cycle acknowledge
- wbs_dat_o  out  32  read data
- dsn_io_out  in  NUM_DESIGNS*NUM_IO  per-design io_out, design d at [d*NUM_IO +: NUM_IO]
- dsn_io_oeb  in  NUM_DESIGNS*NUM_IO  per-design io_oeb, same packing
- dsn_rst_o  out  NUM_DESIGNS  active-high reset per design
- io_out  out  NUM_IO  to pads
- io_oeb  out  NUM_IO  to pads, 1 = input/tristate
- busy_o  out  1  high whenever state != ACTIVE

Behaviour:
- Single clock domain. Reset is asynchronous and active-high, with clock wb_clk_i and reset wb_rst_i.
- On reset: state=HOLD, sel=DEFAULT_SEL, cnt=RST_HOLD-1, io_oeb=all 1, io_out=0, dsn_rst_o=all 1, wbs_ack_o=0, wbs_dat_o=0, err=0, busy_o=1.
- Asserting reset in any state, including mid-switch, returns immediately to these values.
- FSM states:
  - ACTIVE: pads route design sel; dsn_rst_o = ~(1<<sel). Pending switch -> DRAIN, cnt=GUARD_CYC-1, sel<=new value.
  - DRAIN: pads tristated (oeb=1, out=0); all dsn_rst_o=1. At cnt==0 -> HOLD, cnt=RST_HOLD-1.
  - HOLD: pads tristated; all dsn_rst_o=1. At cnt==0 -> ACTIVE.
- io_out/io_oeb are registered, so routing takes effect 1 cycle after the state change. dsn_rst_o is also registered.
- A switch from ACTIVE takes GUARD_CYC+RST_HOLD cycles of busy, counted from the cycle after the CTRL write is acked.
- The counter width is wide enough for max(GUARD_CYC,RST_HOLD).
- Wishbone decode: hit = cyc&stb&(adr[31:8]==BASE_ADDR[31:8]).
  - wbs_ack_o asserts the cycle after a hit with ack low, for one cycle only; no two consecutive acks.
  - Non-hits are never acked.
- Register map (word offsets):
  - 0x00 CTRL: W bits[2:0]=requested sel; R returns the current sel.
  - 0x04 STATUS (R): [2:0] sel, [5:4] state (0 ACTIVE, 1 DRAIN, 2 HOLD), [6] busy, [8] err. Writing 1 to bit 8 clears err.
  - Other offsets: read 0; writes are acked and ignored.
- CTRL write rules:
  - Accepted only in ACTIVE with value < NUM_DESIGNS; starts a switch.
  - Writing the current sel is valid and performs a full soft-reset switch.
  - Value >= NUM_DESIGNS, or any CTRL write while busy: acked, no effect, err<=1.
  - CTRL write with sel[0]=0: acked, ignored, err unchanged.
- If an err-clear and an err-set occur in the same cycle, set wins.
- wbs_dat_o is valid in the ack cycle and 0 otherwise.

Decomposition:
- Package io_mux_pkg holds:
  - state enum (ACTIVE/DRAIN/HOLD)
  - register offsets CTRL_OFS=0x00, STATUS_OFS=0x04
  - STATUS bit positions
- One sub-module is natural: io_mux_wb_regs (Wishbone decode, ack, CTRL/STATUS, err). It emits a one-cycle switch_req plus req_sel to the sequencer/pad-mux in the top.

Test Plan:
- Reset: assert wb_rst_i mid-clock → outputs immediately oeb=all 1, dsn_rst_o=4'b1111, busy_o=1. After release, busy_o falls after 16 cycles; dsn_rst_o=4'b1110; pads follow dsn_io_*[37:0] one cycle later.
- Switch 0→2: write CTRL=2. Ack 1 cycle later; busy for exactly 24 cycles with pads tristated. Then dsn_rst_o=4'b1011 and io_out=dsn_io_out[113:76]. STATUS read returns 0x002 after completion.
- Busy and invalid writes: write CTRL=1 during DRAIN → sel unchanged, STATUS[8]=1. Write STATUS=0x100 → err cleared. Write CTRL=5 while ACTIVE → no switch, err=1.
- Same-sel soft reset: with sel=2 active, write CTRL=2 → full 24-cycle sequence; design 2 reset high throughout, released at end.
- Reset mid-HOLD during a switch to 3 → sel returns to DEFAULT_SEL=0; state HOLD with cnt=15.
- Bus protocol: address 0x3000_0100 → no ack. Hold cyc/stb on 0x3000_0004 for 4 cycles → ack pulses on alternate cycles. Read of 0x3000_0010 → 0.

Source files
------------

// File: rtl/io_mux_pkg.sv
// Shared types and register map for the user I/O pad multiplexer.
package io_mux_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam int SEL_W = 3;

  localparam logic [7:0] CTRL_OFS   = 8'h00;
  localparam logic [7:0] STATUS_OFS = 8'h04;

  localparam int STAT_SEL_LSB   = 0;
  localparam int STAT_STATE_LSB = 4;
  localparam int STAT_BUSY_BIT  = 6;
  localparam int STAT_ERR_BIT   = 8;

endpackage

// File: rtl/io_mux_wb_regs.sv
// Wishbone slave: address decode, single-cycle ack, CTRL/STATUS registers
// and the sticky error flag. Emits a one-cycle switch request to the sequencer.
module io_mux_wb_regs
  import io_mux_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          NUM_DESIGNS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cyc,
  input  logic             stb,
  input  logic             we,
  input  logic [31:0]      adr,
  input  logic [31:0]      dat_w,
  input  logic [3:0]       byte_sel,
  output logic             ack,
  output logic [31:0]      dat_r,
  input  logic [SEL_W-1:0] cur_sel,
  input  state_t           state,
  output logic             switch_req,
  output logic [SEL_W-1:0] req_sel
);

  logic        hit, accept, is_ctrl, is_status;
  logic        ctrl_wr, ctrl_ok, ctrl_bad, err_clr;
  logic        err;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign hit       = cyc & stb & (adr[31:8] == BASE_ADDR[31:8]);
  // Never accept in the ack cycle, so acks can not run back to back.
  assign accept    = hit & ~ack;
  assign is_ctrl   = (adr[7:0] == CTRL_OFS);
  assign is_status = (adr[7:0] == STATUS_OFS);

  assign ctrl_wr  = accept & we & is_ctrl & byte_sel[0];
  assign ctrl_ok  = ctrl_wr & (state == ST_ACTIVE) & (int'(dat_w[SEL_W-1:0]) < NUM_DESIGNS);
  assign ctrl_bad = ctrl_wr & ~ctrl_ok;
  assign err_clr  = accept & we & is_status & dat_w[STAT_ERR_BIT];

  assign unused_bits = ^{dat_w[31:STAT_ERR_BIT+1], dat_w[STAT_ERR_BIT-1:SEL_W], byte_sel[3:1]};

  // Read data selection for the register being addressed.
  always_comb begin
    rd_val = '0;
    if (is_ctrl) begin
      rd_val[SEL_W-1:0] = cur_sel;
    end else if (is_status) begin
      rd_val[STAT_SEL_LSB +: SEL_W] = cur_sel;
      rd_val[STAT_STATE_LSB +: 2]   = state;
      rd_val[STAT_BUSY_BIT]         = (state != ST_ACTIVE);
      rd_val[STAT_ERR_BIT]          = err;
    end
  end

  // Bus response, switch request pulse and sticky error (set beats clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack        <= 1'b0;
      dat_r      <= '0;
      err        <= 1'b0;
      switch_req <= 1'b0;
      req_sel    <= '0;
    end else begin
      ack        <= accept;
      dat_r      <= (accept & ~we) ? rd_val : '0;
      switch_req <= ctrl_ok;
      if (ctrl_ok) req_sel <= dat_w[SEL_W-1:0];
      if (ctrl_bad)     err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: rtl/io_mux_controller.sv
// Pad multiplexer and switch sequencer for the shared user I/O pads.
//
// state  | meaning
// ACTIVE | selected design drives the pads, all others held in reset
// DRAIN  | pads tristated, every design in reset, GUARD_CYC cycles
// HOLD   | pads tristated, every design in reset, RST_HOLD cycles
module io_mux_controller
  import io_mux_pkg::*;
#(
  parameter int          NUM_IO      = 38,
  parameter int          NUM_DESIGNS = 4,
  parameter int          DEFAULT_SEL = 0,
  parameter int          GUARD_CYC   = 8,
  parameter int          RST_HOLD    = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          wbs_cyc_i,
  input  logic                          wbs_stb_i,
  input  logic                          wbs_we_i,
  input  logic [31:0]                   wbs_adr_i,
  input  logic [31:0]                   wbs_dat_i,
  input  logic [3:0]                    wbs_sel_i,
  output logic                          wbs_ack_o,
  output logic [31:0]                   wbs_dat_o,
  input  logic [NUM_DESIGNS*NUM_IO-1:0] dsn_io_out,
  input  logic [NUM_DESIGNS*NUM_IO-1:0] dsn_io_oeb,
  output logic [NUM_DESIGNS-1:0]        dsn_rst_o,
  output logic [NUM_IO-1:0]             io_out,
  output logic [NUM_IO-1:0]             io_oeb,
  output logic                          busy_o
);

  localparam int MAX_CYC = (GUARD_CYC > RST_HOLD) ? GUARD_CYC : RST_HOLD;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [SEL_W-1:0]       sel, sel_nxt;
  logic                   switch_req;
  logic [SEL_W-1:0]       req_sel;
  logic [NUM_IO-1:0]      io_out_nxt, io_oeb_nxt;
  logic [NUM_DESIGNS-1:0] dsn_rst_nxt;

  io_mux_wb_regs #(
    .BASE_ADDR  (BASE_ADDR),
    .NUM_DESIGNS(NUM_DESIGNS)
  ) u_regs (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .cyc       (wbs_cyc_i),
    .stb       (wbs_stb_i),
    .we        (wbs_we_i),
    .adr       (wbs_adr_i),
    .dat_w     (wbs_dat_i),
    .byte_sel  (wbs_sel_i),
    .ack       (wbs_ack_o),
    .dat_r     (wbs_dat_o),
    .cur_sel   (sel),
    .state     (state),
    .switch_req(switch_req),
    .req_sel   (req_sel)
  );

  assign busy_o = (state != ST_ACTIVE);

  // State, down-counter and selected design registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= ST_HOLD;
      cnt   <= CNT_W'(RST_HOLD - 1);
      sel   <= SEL_W'(DEFAULT_SEL);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sel   <= sel_nxt;
    end
  end

  // Switch sequencing: ACTIVE -> DRAIN -> HOLD -> ACTIVE on counter expiry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel;
    case (state)
      ST_ACTIVE: begin
        if (switch_req) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = CNT_W'(GUARD_CYC - 1);
          sel_nxt   = req_sel;
        end
      end
      ST_DRAIN: begin
        if (cnt == '0) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = CNT_W'(RST_HOLD - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) state_nxt = ST_ACTIVE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: begin
        state_nxt = ST_HOLD;
        cnt_nxt   = CNT_W'(RST_HOLD - 1);
      end
    endcase
  end

  // Pad routing and per-design resets derived from the current state.
  always_comb begin
    io_out_nxt  = '0;
    io_oeb_nxt  = '1;
    dsn_rst_nxt = '1;
    if (state == ST_ACTIVE) begin
      io_out_nxt  = dsn_io_out[int'(sel)*NUM_IO +: NUM_IO];
      io_oeb_nxt  = dsn_io_oeb[int'(sel)*NUM_IO +: NUM_IO];
      dsn_rst_nxt = ~(NUM_DESIGNS'(1) << sel);
    end
  end

  // Registered pad and reset outputs, safe values while in reset.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      io_out    <= '0;
      io_oeb    <= '1;
      dsn_rst_o <= '1;
    end else begin
      io_out    <= io_out_nxt;
      io_oeb    <= io_oeb_nxt;
      dsn_rst_o <= dsn_rst_nxt;
    end
  end

endmodule
